// File: rtl/boolean_oai_pipe.sv
// Bitwise and/or/invert function unit with a two-stage valid/ready pipeline.
// Stage 2 also presents the ones-count and a zero flag, and a counter tracks consumed results.
module boolean_oai_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic [CW-1:0]    out_ones,
    output logic             out_zero,
    output logic [15:0]      txn_count
);

    typedef enum logic [1:0] {
        MODE_OAI = 2'd0,
        MODE_AOI = 2'd1,
        MODE_OA  = 2'd2,
        MODE_AO  = 2'd3
    } mode_e;

    logic [WIDTH-1:0] func_d;
    logic [WIDTH-1:0] d_s1;
    logic             s1_valid;
    logic             s2_load;
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    ones_s1;

    always_comb begin
        func_d = '0;
        case (mode_e'(in_mode))
            MODE_OAI: func_d = ~((in_a | in_b) & in_c);
            MODE_AOI: func_d = ~((in_a & in_b) | in_c);
            MODE_OA:  func_d =   (in_a | in_b) & in_c;
            MODE_AO:  func_d =   (in_a & in_b) | in_c;
            default:  func_d = '0;
        endcase
    end

    always_comb begin
        ones_s1 = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones_s1 = ones_s1 + CW'(d_s1[i]);
        end
    end

    // in_ready depends only on out_ready and registered valids, never on in_valid
    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_load;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_s1     <= '0;
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            d_s1     <= func_d;
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_d     <= '0;
            out_ones  <= '0;
            out_zero  <= 1'b0;
            out_valid <= 1'b0;
        end else if (s2_load) begin
            out_d     <= d_s1;
            out_ones  <= ones_s1;
            out_zero  <= (d_s1 == '0);
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (out_xfer) begin
            txn_count <= txn_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_boolean_oai_pipe.sv
// Self-checking bench for boolean_oai_pipe at WIDTH 8, 7 and 1.
// Expected results come from a bitwise reference function and a FIFO scoreboard.
module tb_boolean_oai_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 8
    logic       iv8, ir8, ov8, or8, zero8;
    logic [7:0] a8, b8, c8, od8;
    logic [1:0] m8;
    logic [3:0] ones8;
    logic [15:0] txn8;
    // WIDTH = 7
    logic       iv7, ir7, ov7, or7, zero7;
    logic [6:0] a7, b7, c7, od7;
    logic [1:0] m7;
    logic [2:0] ones7;
    logic [15:0] txn7;
    // WIDTH = 1
    logic       iv1, ir1, ov1, or1, zero1;
    logic [0:0] a1, b1, c1, od1;
    logic [1:0] m1;
    logic [0:0] ones1;
    logic [15:0] txn1;

    int checks = 0;
    int passes = 0;

    boolean_oai_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .in_c(c8), .in_mode(m8),
        .out_valid(ov8), .out_ready(or8), .out_d(od8), .out_ones(ones8),
        .out_zero(zero8), .txn_count(txn8)
    );
    boolean_oai_pipe #(.WIDTH(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv7), .in_ready(ir7),
        .in_a(a7), .in_b(b7), .in_c(c7), .in_mode(m7),
        .out_valid(ov7), .out_ready(or7), .out_d(od7), .out_ones(ones7),
        .out_zero(zero7), .txn_count(txn7)
    );
    boolean_oai_pipe #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .in_a(a1), .in_b(b1), .in_c(c1), .in_mode(m1),
        .out_valid(ov1), .out_ready(or1), .out_d(od1), .out_ones(ones1),
        .out_zero(zero1), .txn_count(txn1)
    );

    function automatic logic [7:0] model8(input logic [1:0] m, input logic [7:0] a, b, c);
        case (m)
            2'd0:    return ~((a | b) & c);
            2'd1:    return ~((a & b) | c);
            2'd2:    return (a | b) & c;
            default: return (a & b) | c;
        endcase
    endfunction

    task automatic test_reset;
        iv8 = 0; or8 = 0; a8 = '0; b8 = '0; c8 = '0; m8 = '0;
        iv7 = 0; or7 = 0; a7 = '0; b7 = '0; c7 = '0; m7 = '0;
        iv1 = 0; or1 = 0; a1 = '0; b1 = '0; c1 = '0; m1 = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ov8, od8, ones8, zero8, txn8} !== '0)
            $display("FAIL reset_state: got ov=%b d=%h ones=%0d z=%b txn=%0d, want all 0",
                     ov8, od8, ones8, zero8, txn8);
        else passes++;
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (ir8 !== 1'b1 || ir7 !== 1'b1 || ir1 !== 1'b1)
            $display("FAIL reset_in_ready: got %b%b%b, want 111", ir8, ir7, ir1);
        else passes++;
    endtask

    task automatic test_modes;
        logic [1:0] tm [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] ta [4] = '{8'h0F, 8'hAA, 8'hAA, 8'hAA};
        logic [7:0] tb [4] = '{8'hF0, 8'hCC, 8'hCC, 8'hCC};
        logic [7:0] tc [4] = '{8'h3C, 8'h01, 8'h01, 8'h01};
        logic [7:0] td [4] = '{8'hC3, 8'h76, 8'h00, 8'h89};
        logic [3:0] tn [4] = '{4'd4, 4'd5, 4'd0, 4'd3};
        logic       tz [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            or8 = 1; iv8 = 1; m8 = tm[i]; a8 = ta[i]; b8 = tb[i]; c8 = tc[i];
            @(negedge clk);
            iv8 = 0;
            checks++;
            if (ov8 !== 1'b0) $display("FAIL latency_early mode%0d: got out_valid=%b, want 0", i, ov8);
            else passes++;
            @(negedge clk);
            checks++;
            if (ov8 !== 1'b1 || od8 !== td[i] || ones8 !== tn[i] || zero8 !== tz[i])
                $display("FAIL mode%0d: got v=%b d=%h ones=%0d z=%b, want v=1 d=%h ones=%0d z=%b",
                         i, ov8, od8, ones8, zero8, td[i], tn[i], tz[i]);
            else passes++;
            checks++;
            if (model8(tm[i], ta[i], tb[i], tc[i]) !== od8)
                $display("FAIL model_mode%0d: got %h, want %h", i, od8, model8(tm[i], ta[i], tb[i], tc[i]));
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [7:0] ea [3];
        logic [7:0] eb [3];
        logic [7:0] ec [3];
        logic [1:0] em [3];
        logic [7:0] ex [3];
        for (int i = 0; i < 3; i++) begin
            ea[i] = 8'($urandom); eb[i] = 8'($urandom); ec[i] = 8'($urandom); em[i] = 2'($urandom);
            ex[i] = model8(em[i], ea[i], eb[i], ec[i]);
        end
        or8 = 0;
        for (int i = 0; i < 3; i++) begin
            iv8 = 1; a8 = ea[i]; b8 = eb[i]; c8 = ec[i]; m8 = em[i];
            #1;
            checks++;
            if (ir8 !== (i < 2 ? 1'b1 : 1'b0))
                $display("FAIL bp_in_ready%0d: got %b, want %b", i, ir8, (i < 2));
            else passes++;
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (ir8 !== 1'b0 || ov8 !== 1'b1 || od8 !== ex[0])
            $display("FAIL bp_hold: got ir=%b v=%b d=%h, want ir=0 v=1 d=%h", ir8, ov8, od8, ex[0]);
        else passes++;
        or8 = 1;
        #1;
        checks++;
        if (ir8 !== 1'b1) $display("FAIL bp_release_ready: got %b, want 1", ir8);
        else passes++;
        @(negedge clk);
        iv8 = 0;
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (ov8 !== 1'b1 || od8 !== ex[i])
                $display("FAIL bp_order%0d: got v=%b d=%h, want v=1 d=%h", i, ov8, od8, ex[i]);
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (ov8 !== 1'b0) $display("FAIL bp_drained: got out_valid=%b, want 0", ov8);
        else passes++;
    endtask

    // rand_bp = 0 keeps out_ready and in_valid high, as in plain streaming
    task automatic test_stream(input int n, input bit rand_bp);
        logic [7:0] q [$];
        int sent = 0;
        int got = 0;
        int guard = 0;
        logic [15:0] base;
        logic [7:0] e;
        base = txn8;
        while ((sent < n || q.size() != 0 || ov8) && guard < 10 * n + 20) begin
            guard++;
            or8 = rand_bp ? 1'($urandom) : 1'b1;
            iv8 = (sent < n) && (rand_bp ? 1'($urandom) : 1'b1);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); m8 = 2'($urandom);
            #1;
            if (ov8) begin
                e = (q.size() != 0) ? q[0] : ~od8;
                checks++;
                if (od8 !== e || ones8 !== 4'($countones(e)) || zero8 !== (e == 8'h00))
                    $display("FAIL stream_data%0d: got d=%h ones=%0d z=%b, want d=%h ones=%0d z=%b",
                             got, od8, ones8, zero8, e, $countones(e), (e == 8'h00));
                else passes++;
                if (or8) begin
                    if (q.size() != 0) void'(q.pop_front());
                    got++;
                end
            end
            if (iv8 && ir8) begin
                q.push_back(model8(m8, a8, b8, c8));
                sent++;
            end
            @(negedge clk);
        end
        iv8 = 0;
        checks++;
        if (got != n || sent != n)
            $display("FAIL stream_count: got %0d results from %0d sent, want %0d", got, sent, n);
        else passes++;
        checks++;
        if (txn8 !== 16'(base + 16'(n)))
            $display("FAIL stream_txn: got %0d, want %0d", txn8, 16'(base + 16'(n)));
        else passes++;
    endtask

    task automatic test_reset_mid;
        or8 = 0; iv8 = 1;
        repeat (2) @(negedge clk);
        iv8 = 0;
        checks++;
        if (ov8 !== 1'b1 || ir8 !== 1'b0 || txn8 == 16'd0)
            $display("FAIL rst_mid_full: got v=%b ir=%b txn=%0d, want v=1 ir=0 txn>0", ov8, ir8, txn8);
        else passes++;
        #2 rst_n = 0;
        #1;
        checks++;
        if (ov8 !== 1'b0 || txn8 !== 16'd0 || od8 !== 8'h00)
            $display("FAIL rst_mid_async: got v=%b txn=%0d d=%h, want 0 0 00", ov8, txn8, od8);
        else passes++;
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) $display("FAIL rst_mid_release: got ir=%b v=%b, want 1 0", ir8, ov8);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_narrow;
        or7 = 1; iv7 = 1; m7 = 2'd3; a7 = 7'h00; b7 = 7'h00; c7 = 7'h7F;
        or1 = 1; iv1 = 1; m1 = 2'd0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        #1;
        checks++;
        if (ir7 !== 1'b1 || ir1 !== 1'b1) $display("FAIL narrow_ready: got %b%b, want 11", ir7, ir1);
        else passes++;
        @(negedge clk);
        iv7 = 0; iv1 = 0;
        @(negedge clk);
        checks++;
        if (ov7 !== 1'b1 || od7 !== 7'h7F || ones7 !== 3'd7 || zero7 !== 1'b0)
            $display("FAIL w7_all_ones: got v=%b d=%h ones=%0d z=%b, want 1 7f 7 0", ov7, od7, ones7, zero7);
        else passes++;
        checks++;
        if (ov1 !== 1'b1 || od1 !== 1'b1 || ones1 !== 1'b1 || zero1 !== 1'b0)
            $display("FAIL w1_all_ones: got v=%b d=%b ones=%0d z=%b, want 1 1 1 0", ov1, od1, ones1, zero1);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [15:0] base;
        int consumed = 0;
        base = txn1;
        or1 = 1; iv1 = 1; m1 = 2'd3; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            if (i == 65536) iv1 = 0;
            #1;
            if (ov1 && or1) consumed++;
            @(negedge clk);
        end
        checks++;
        if (consumed != 65536 || ov1 !== 1'b0)
            $display("FAIL wrap_count: got %0d consumed v=%b, want 65536 v=0", consumed, ov1);
        else passes++;
        checks++;
        if (txn1 !== base)
            $display("FAIL wrap_txn: got %0d, want %0d", txn1, base);
        else passes++;
        checks++;
        if (od1 !== 1'b0 || zero1 !== 1'b1 || ones1 !== 1'b0)
            $display("FAIL w1_zero: got d=%b z=%b ones=%0d, want 0 1 0", od1, zero1, ones1);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_stream(100, 1'b0);
        test_stream(60, 1'b1);
        test_reset_mid();
        test_narrow();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
